// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, shared-ALU and response signals of the two-port ALU arbiter
interface alu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [2:0]  req0_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [2:0]  req1_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_c;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_data;
  modport slave (
    input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, alu_c, resp_ready,
    output req_ready, alu_a, alu_b, alu_op, resp_valid, resp_data
  );
  modport master (
    output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, alu_c, resp_ready,
    input  req_ready, alu_a, alu_b, alu_op, resp_valid, resp_data
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters, one result held until taken
module alu_arbiter (
  input logic clk,
  input logic reset,
  alu_arbiter_if.slave bus
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_n;
  logic prio, owner, win, grant, done;
  logic [31:0] data;
  always_comb begin
    win = bus.req_valid[prio] ? prio : ~prio;
    grant = (state == IDLE) && |bus.req_valid;
    done = (state == HOLD) && bus.resp_ready[owner];
    state_n = grant ? HOLD : done ? IDLE : state;
    bus.req_ready = grant ? (win ? 2'b10 : 2'b01) : 2'b00;
    bus.resp_valid = (state == HOLD) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    // requester 0 is the default source whenever nobody is being granted
    bus.alu_a = (grant && win) ? bus.req1_a : bus.req0_a;
    bus.alu_b = (grant && win) ? bus.req1_b : bus.req0_b;
    bus.alu_op = (grant && win) ? bus.req1_op : bus.req0_op;
    bus.resp_data = data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      prio <= 1'b0;
      owner <= 1'b0;
      data <= '0;
    end else begin
      state <= state_n;
      if (grant) begin
        prio <= ~win;
        owner <= win;
        data <= bus.alu_c;
      end
    end
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have no parameters; all widths fixed (data 32 bits, op 3 bits).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid[1:0]  input  2  per-requester operation request (bit i = requester i).
REQ-005 req_ready[1:0]  output  2  per-requester grant; transfer occurs when req_valid[i] && req_ready[i].
REQ-006 req0_a, req0_b, req1_a, req1_b  input  32 each  operands A/B per requester.
REQ-007 req0_op, req1_op  input  3 each  ALUOp code (0 add, 1 sub, 2 and, 3 or, 4 srl, 5 sra, 6/7 zero).
REQ-008 alu_a, alu_b  output  32 each  operands driven to the shared combinational ALU.
REQ-009 alu_op  output  3  ALUOp driven to the shared ALU.
REQ-010 alu_c  input  32  ALU result, combinational from alu_a/alu_b/alu_op.
REQ-011 resp_valid[1:0]  output  2  result available for requester i.
REQ-012 resp_ready[1:0]  input  2  requester i accepts result.
REQ-013 resp_data  output  32  registered result, valid while any resp_valid bit is high.

Function
REQ-014 SHALL implement FSM with states IDLE and HOLD.
REQ-015 In IDLE, req_ready SHALL be one-hot to the winning requester when any req_valid is high, else 2'b00; in HOLD, req_ready SHALL be 2'b00.
REQ-016 Arbitration SHALL be round-robin: pointer prio (1 bit) names the preferred requester; the preferred requester wins if valid, otherwise the other wins if valid.
REQ-017 On a grant, prio SHALL update to the non-granted index; with no grant, prio SHALL hold.
REQ-018 In IDLE, alu_a/alu_b/alu_op SHALL combinationally mux the winner's operands/op; with no valid request they SHALL drive requester 0's inputs.
REQ-019 On the grant edge, resp_data SHALL capture alu_c, owner register SHALL capture winner index, FSM SHALL enter HOLD.
REQ-020 Latency: request granted in cycle N SHALL produce resp_valid[owner]=1 in cycle N+1.
REQ-021 In HOLD, resp_valid SHALL be one-hot at owner; resp_data and owner SHALL stay stable until handshake.
REQ-022 When resp_valid[owner] && resp_ready[owner], FSM SHALL return to IDLE next cycle; new grant earliest that IDLE cycle (throughput one op per 2 cycles minimum).
REQ-023 resp_ready of the non-owner SHALL be ignored.
REQ-024 Operand/op changes by a requester while not granted SHALL have no effect on state.
REQ-025 Result arithmetic SHALL be whatever alu_c returns; arbiter SHALL NOT modify, sign-extend or truncate it.
REQ-026 Simultaneous req_valid=2'b11 in consecutive IDLE windows SHALL alternate grants 0,1,0,1... starting from current prio.

Reset
REQ-027 Reset SHALL set state=IDLE, prio=0, owner=0, resp_data=0, resp_valid=2'b00.
REQ-028 Reset asserted during HOLD SHALL discard the pending result; resp_valid SHALL be 2'b00 the cycle after the reset edge.
REQ-029 Reset SHALL take priority over any grant or response handshake in the same cycle.

Verification
REQ-030 After reset, req_valid=01, req0 a=5 b=3 op=1 -> req_ready=01 same cycle; next cycle resp_valid=01, resp_data=2.
REQ-031 req_valid=11 held, resp_ready=11, req0 op=0 a=1 b=1, req1 op=3 a=0xF0 b=0x0F -> grants alternate 0,1,0; resp_data 2, 0xFF, 2.
REQ-032 Grant req1 op=5 a=0x80000000 b=4, resp_ready=00 for 5 cycles -> resp_valid=10 held, resp_data=0xF8000000 stable, req_ready=00 throughout; release resp_ready=10 -> IDLE next cycle.
REQ-033 req0 op=4 a=0xFFFFFFFF b=32 -> resp_data=0; op=6 any operands -> resp_data=0.
REQ-034 Reset pulsed while in HOLD with resp_valid=01 -> resp_valid=00, prio=0, req_ready resumes arbitration next cycle.
REQ-035 In HOLD owner=0, assert resp_ready=10 only -> no handshake, remains HOLD.
